// File: rtl/bram_result_drainer_pkg.sv
// Shared definitions for the result-bank drainer: run-state encoding (common with
// the BRAM accessor's status) and default widths.
package bram_result_drainer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } drain_state_e;

   localparam int DEF_CNT_BIT     = 31;
   localparam int DEF_DWIDTH      = 64;
   localparam int DEF_AWIDTH      = 8;
   localparam int DEF_MEM_SIZE    = 256;
   localparam int BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/bram_result_drainer_drain_fifo2.sv
// Two-entry register FIFO that buffers BRAM read data ahead of the output stream.
// A push and pop in the same cycle leave the count unchanged, even when full.
module drain_fifo2 #(
   parameter int DWIDTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        count,
   output logic [DWIDTH-1:0] head
);

   logic [DWIDTH-1:0] mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/bram_result_drainer.sv
// Drains run_count_i words of result bank 1, starting at address 0, onto a
// valid/ready stream. Read issue is credit-limited so the 2-entry FIFO never overflows.
module bram_result_drainer
   import bram_result_drainer_pkg::*;
#(
   parameter int CNT_BIT  = DEF_CNT_BIT,
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int MEM_SIZE = DEF_MEM_SIZE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_run_i,
   input  logic [CNT_BIT-1:0] run_count_i,
   output logic               idle_o,
   output logic               run_o,
   output logic               done_o,
   output logic [AWIDTH-1:0]  addr_b1_o,
   output logic               ce_b1_o,
   output logic               we_b1_o,
   output logic [DWIDTH-1:0]  d_b1_o,
   input  logic [DWIDTH-1:0]  q_b1_i,
   output logic               m_valid_o,
   output logic [DWIDTH-1:0]  m_data_o,
   output logic               m_last_o,
   input  logic               m_ready_i
);

   drain_state_e                 state;
   logic [CNT_BIT-1:0]           count_q;
   logic [CNT_BIT-1:0]           issued;
   logic [CNT_BIT-1:0]           accepted;
   logic [BRAM_RD_LATENCY-1:0]   inflight;
   logic [1:0]                   fifo_cnt;
   logic [2:0]                   occupancy;
   logic                         pop;
   logic                         ce;

   // Stream handshake: a beat transfers on any rising edge where m_valid_o && m_ready_i;
   // m_valid_o, once high, stays high with stable data/last until that transfer happens.
   assign pop = m_valid_o && m_ready_i;

   // Words held or on their way: buffered + in flight, less the one leaving this edge.
   assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight[0]} - {2'b00, pop};
   assign ce        = (state == ST_RUN) && (issued < count_q) && (occupancy < 3'd2);

   assign ce_b1_o   = ce;
   assign addr_b1_o = AWIDTH'(32'(issued) % 32'(MEM_SIZE));
   assign we_b1_o   = 1'b0;
   assign d_b1_o    = '0;

   assign idle_o    = (state == ST_IDLE);
   assign run_o     = (state == ST_RUN);
   assign done_o    = (state == ST_DONE);

   assign m_valid_o = (fifo_cnt != 2'd0);
   assign m_last_o  = m_valid_o && (accepted == count_q - CNT_BIT'(1));

   drain_fifo2 #(
      .DWIDTH (DWIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight[0]),
      .push_data (q_b1_i),
      .pop       (pop),
      .count     (fifo_cnt),
      .head      (m_data_o)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         count_q  <= '0;
         issued   <= '0;
         accepted <= '0;
         inflight <= '0;
      end else begin
         inflight <= BRAM_RD_LATENCY'(ce);
         unique case (state)
            ST_IDLE: begin
               if (start_run_i) begin
                  count_q  <= run_count_i;
                  issued   <= '0;
                  accepted <= '0;
                  state    <= (run_count_i == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (ce) begin
                  issued <= issued + CNT_BIT'(1);
               end
               if (pop) begin
                  accepted <= accepted + CNT_BIT'(1);
                  // Leaving on the final acceptance edge puts done_o in the very next cycle.
                  if (accepted == count_q - CNT_BIT'(1)) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
